// File: rtl/arrow_judge.sv
// Judges key presses against each non-empty arrow pattern inside a WINDOW-cycle window; keeps score and combo.
// Latency: judgement registered one cycle after the deciding cycle; no backpressure, a new pattern force-closes the open window.
module arrow_judge #(
    parameter int WINDOW      = 25000000,
    parameter int PERFECT_WIN = 5000000,
    parameter int SCORE_W     = 16,
    parameter int COMBO_W     = 10
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               arrow_valid,
    input  logic [3:0]         arrows,
    input  logic [3:0]         keys,
    output logic               judge_valid,
    output logic [1:0]         judge,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [COMBO_W-1:0] max_combo,
    output logic               busy
);

    localparam int EW = $clog2(WINDOW);
    localparam logic [EW-1:0] LAST = EW'(WINDOW - 1);
    localparam logic [EW:0]   PWIN = (EW + 1)'(PERFECT_WIN);

    typedef enum logic {IDLE, OPEN} state_t;
    typedef enum logic [1:0] {J_NONE, J_PERFECT, J_GOOD, J_MISS} judge_t;

    state_t        state, state_n;
    judge_t        dec;
    logic [3:0]    keys_q, target, target_n, hit, hit_n;
    logic [3:0]    press, wrong, mask;
    logic [EW-1:0] elapsed, elapsed_n;

    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_n;
    logic [COMBO_W:0]   combo_sum;
    logic [COMBO_W-1:0] combo_hit;

    assign busy = (state == OPEN);

    always_comb begin
        press     = keys & ~keys_q;
        wrong     = press & ~target;
        mask      = hit | (press & target);
        dec       = J_NONE;
        state_n   = state;
        target_n  = target;
        hit_n     = hit;
        elapsed_n = elapsed;

        if (state == OPEN) begin
            // wrong press beats completion, completion beats timeout
            if (wrong != 4'd0)
                dec = J_MISS;
            else if (mask == target)
                dec = ({1'b0, elapsed} < PWIN) ? J_PERFECT : J_GOOD;
            else if (elapsed == LAST)
                dec = J_MISS;

            if (arrow_valid && dec == J_NONE)
                dec = J_MISS;

            if (dec != J_NONE) begin
                state_n = IDLE;
            end else begin
                hit_n     = mask;
                elapsed_n = elapsed + EW'(1);
            end
        end

        if (arrow_valid) begin
            if (arrows != 4'd0) begin
                state_n   = OPEN;
                target_n  = arrows;
                hit_n     = 4'd0;
                elapsed_n = '0;
            end else begin
                state_n = IDLE;
            end
        end
    end

    always_comb begin
        score_sum = {1'b0, score} + ((dec == J_PERFECT) ? (SCORE_W + 1)'(3) : (SCORE_W + 1)'(1));
        score_n   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        combo_sum = {1'b0, combo} + (COMBO_W + 1)'(1);
        combo_hit = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            target      <= 4'd0;
            hit         <= 4'd0;
            elapsed     <= '0;
            keys_q      <= 4'd0;
            judge_valid <= 1'b0;
            judge       <= 2'd0;
            score       <= '0;
            combo       <= '0;
            max_combo   <= '0;
        end else begin
            state       <= state_n;
            target      <= target_n;
            hit         <= hit_n;
            elapsed     <= elapsed_n;
            keys_q      <= keys;
            judge_valid <= (dec != J_NONE);
            if (dec != J_NONE) begin
                judge <= dec;
                if (dec == J_MISS) begin
                    combo <= '0;
                end else begin
                    score <= score_n;
                    combo <= combo_hit;
                    if (combo_hit > max_combo)
                        max_combo <= combo_hit;
                end
            end
        end
    end

endmodule

// File: tb/tb_arrow_judge.sv
// Directed bench for arrow_judge with WINDOW=16, PERFECT_WIN=4.
module tb_arrow_judge;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        arrow_valid = 1'b0;
    logic [3:0]  arrows = 4'd0;
    logic [3:0]  keys = 4'd0;
    logic        judge_valid;
    logic [1:0]  judge;
    logic [15:0] score;
    logic [9:0]  combo;
    logic [9:0]  max_combo;
    logic        busy;

    int   checks = 0;
    int   failures = 0;
    logic seen;

    always #5 Clk = ~Clk;

    arrow_judge #(
        .WINDOW(16),
        .PERFECT_WIN(4),
        .SCORE_W(16),
        .COMBO_W(10)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .arrow_valid(arrow_valid),
        .arrows(arrows),
        .keys(keys),
        .judge_valid(judge_valid),
        .judge(judge),
        .score(score),
        .combo(combo),
        .max_combo(max_combo),
        .busy(busy)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset();
        arrow_valid = 1'b0;
        arrows = 4'd0;
        keys = 4'd0;
        Reset = 1'b0;
        step();
        step();
        Reset = 1'b1;
        step();
    endtask

    task automatic strobe(input logic [3:0] a);
        arrows = a;
        arrow_valid = 1'b1;
        step();
        arrow_valid = 1'b0;
        arrows = 4'd0;
    endtask

    // press at k=0
    task automatic play_perfect(input logic [3:0] a);
        strobe(a);
        keys = a;
        step();
        keys = 4'd0;
        step();
    endtask

    // press at k=4
    task automatic play_good(input logic [3:0] a);
        strobe(a);
        repeat (4) step();
        keys = a;
        step();
        keys = 4'd0;
        step();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (judge_valid !== 1'b0) begin failures++; $display("FAIL rst_jv got=%0d exp=0", judge_valid); end
        checks++; if (judge !== 2'd0) begin failures++; $display("FAIL rst_judge got=%0d exp=0", judge); end
        checks++; if (score !== 16'd0) begin failures++; $display("FAIL rst_score got=%0d exp=0", score); end
        checks++; if (combo !== 10'd0) begin failures++; $display("FAIL rst_combo got=%0d exp=0", combo); end
        checks++; if (max_combo !== 10'd0) begin failures++; $display("FAIL rst_max got=%0d exp=0", max_combo); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0d exp=0", busy); end

        play_perfect(4'b0100);
        checks++; if (score !== 16'd3) begin failures++; $display("FAIL pre_rst_score got=%0d exp=3", score); end

        strobe(4'b0100);
        repeat (5) step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%0d exp=1", busy); end
        Reset = 1'b0;
        #1;
        checks++; if (judge !== 2'd0) begin failures++; $display("FAIL arst_judge got=%0d exp=0", judge); end
        checks++; if (score !== 16'd0) begin failures++; $display("FAIL arst_score got=%0d exp=0", score); end
        checks++; if (combo !== 10'd0) begin failures++; $display("FAIL arst_combo got=%0d exp=0", combo); end
        checks++; if (max_combo !== 10'd0) begin failures++; $display("FAIL arst_max got=%0d exp=0", max_combo); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%0d exp=0", busy); end
        step();
        Reset = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            step();
            if (judge_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL post_rst_jv got=%0d exp=0", seen); end
    endtask

    task automatic test_perfect();
        apply_reset();
        arrows = 4'b0100;
        arrow_valid = 1'b1;
        step();
        arrow_valid = 1'b0;
        arrows = 4'd0;
        step();
        checks++; if (judge_valid !== 1'b0) begin failures++; $display("FAIL perf_early_jv got=%0d exp=0", judge_valid); end
        keys = 4'b0100;
        step();
        checks++; if (judge_valid !== 1'b1) begin failures++; $display("FAIL perf_jv got=%0d exp=1", judge_valid); end
        checks++; if (judge !== 2'b01) begin failures++; $display("FAIL perf_judge got=%0d exp=1", judge); end
        checks++; if (score !== 16'd3) begin failures++; $display("FAIL perf_score got=%0d exp=3", score); end
        checks++; if (combo !== 10'd1) begin failures++; $display("FAIL perf_combo got=%0d exp=1", combo); end
        checks++; if (max_combo !== 10'd1) begin failures++; $display("FAIL perf_max got=%0d exp=1", max_combo); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL perf_busy got=%0d exp=0", busy); end
        keys = 4'd0;
        step();
        checks++; if (judge_valid !== 1'b0) begin failures++; $display("FAIL perf_pulse got=%0d exp=0", judge_valid); end
        checks++; if (judge !== 2'b01) begin failures++; $display("FAIL perf_hold got=%0d exp=1", judge); end
    endtask

    task automatic test_good_rest();
        apply_reset();
        strobe(4'b1111);
        step();
        step();
        keys = 4'b0011;
        repeat (4) step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL chord_busy got=%0d exp=1", busy); end
        checks++; if (judge_valid !== 1'b0) begin failures++; $display("FAIL chord_half_jv got=%0d exp=0", judge_valid); end
        keys = 4'b1111;
        step();
        checks++; if (judge_valid !== 1'b1) begin failures++; $display("FAIL chord_jv got=%0d exp=1", judge_valid); end
        checks++; if (judge !== 2'b10) begin failures++; $display("FAIL chord_judge got=%0d exp=2", judge); end
        checks++; if (score !== 16'd1) begin failures++; $display("FAIL chord_score got=%0d exp=1", score); end
        checks++; if (combo !== 10'd1) begin failures++; $display("FAIL chord_combo got=%0d exp=1", combo); end
        keys = 4'd0;
        step();
        strobe(4'b0000);
        seen = 1'b0;
        repeat (6) begin
            if (judge_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            step();
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rest_beat got=%0d exp=0", seen); end
    endtask

    task automatic test_miss_paths();
        apply_reset();
        play_perfect(4'b0001);
        play_perfect(4'b0010);
        checks++; if (combo !== 10'd2) begin failures++; $display("FAIL pre_combo got=%0d exp=2", combo); end

        strobe(4'b0001);
        keys = 4'b0010;
        step();
        checks++; if (judge_valid !== 1'b1) begin failures++; $display("FAIL wrong_jv got=%0d exp=1", judge_valid); end
        checks++; if (judge !== 2'b11) begin failures++; $display("FAIL wrong_judge got=%0d exp=3", judge); end
        checks++; if (combo !== 10'd0) begin failures++; $display("FAIL wrong_combo got=%0d exp=0", combo); end
        checks++; if (max_combo !== 10'd2) begin failures++; $display("FAIL wrong_max got=%0d exp=2", max_combo); end
        checks++; if (score !== 16'd6) begin failures++; $display("FAIL wrong_score got=%0d exp=6", score); end
        keys = 4'd0;
        step();

        strobe(4'b0010);
        seen = 1'b0;
        repeat (16) begin
            if (judge_valid !== 1'b0) seen = 1'b1;
            step();
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL tmo_early got=%0d exp=0", seen); end
        checks++; if (judge_valid !== 1'b1) begin failures++; $display("FAIL tmo_jv got=%0d exp=1", judge_valid); end
        checks++; if (judge !== 2'b11) begin failures++; $display("FAIL tmo_judge got=%0d exp=3", judge); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tmo_busy got=%0d exp=0", busy); end
        step();

        strobe(4'b0100);
        step();
        step();
        step();
        strobe(4'b1000);
        checks++; if (judge_valid !== 1'b1) begin failures++; $display("FAIL force_jv got=%0d exp=1", judge_valid); end
        checks++; if (judge !== 2'b11) begin failures++; $display("FAIL force_judge got=%0d exp=3", judge); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL force_busy got=%0d exp=1", busy); end
        seen = 1'b0;
        repeat (15) begin
            step();
            if (judge_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL force_restart got=%0d exp=0", seen); end
        step();
        checks++; if (judge_valid !== 1'b1) begin failures++; $display("FAIL force_tmo_jv got=%0d exp=1", judge_valid); end
        checks++; if (judge !== 2'b11) begin failures++; $display("FAIL force_tmo_judge got=%0d exp=3", judge); end
    endtask

    task automatic test_edge_cases();
        apply_reset();
        keys = 4'b0100;
        step();
        strobe(4'b0100);
        repeat (15) step();
        checks++; if (judge_valid !== 1'b0) begin failures++; $display("FAIL held_early got=%0d exp=0", judge_valid); end
        step();
        checks++; if (judge_valid !== 1'b1) begin failures++; $display("FAIL held_jv got=%0d exp=1", judge_valid); end
        checks++; if (judge !== 2'b11) begin failures++; $display("FAIL held_judge got=%0d exp=3", judge); end
        checks++; if (score !== 16'd0) begin failures++; $display("FAIL held_score got=%0d exp=0", score); end
        keys = 4'd0;
        step();

        strobe(4'b0001);
        repeat (15) step();
        keys = 4'b0001;
        step();
        checks++; if (judge !== 2'b10) begin failures++; $display("FAIL k15_judge got=%0d exp=2", judge); end
        checks++; if (score !== 16'd1) begin failures++; $display("FAIL k15_score got=%0d exp=1", score); end
        checks++; if (combo !== 10'd1) begin failures++; $display("FAIL k15_combo got=%0d exp=1", combo); end
        keys = 4'd0;
        step();

        strobe(4'b1000);
        repeat (3) step();
        keys = 4'b1000;
        step();
        checks++; if (judge !== 2'b01) begin failures++; $display("FAIL k3_judge got=%0d exp=1", judge); end
        checks++; if (score !== 16'd4) begin failures++; $display("FAIL k3_score got=%0d exp=4", score); end
        keys = 4'd0;
        step();

        strobe(4'b1000);
        repeat (4) step();
        keys = 4'b1000;
        step();
        checks++; if (judge !== 2'b10) begin failures++; $display("FAIL k4_judge got=%0d exp=2", judge); end
        checks++; if (score !== 16'd5) begin failures++; $display("FAIL k4_score got=%0d exp=5", score); end
        checks++; if (combo !== 10'd3) begin failures++; $display("FAIL k4_combo got=%0d exp=3", combo); end
        keys = 4'd0;
        step();

        strobe(4'b0011);
        keys = 4'b0001;
        step();
        keys = 4'b0000;
        step();
        keys = 4'b0001;
        step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL repress_busy got=%0d exp=1", busy); end
        checks++; if (judge_valid !== 1'b0) begin failures++; $display("FAIL repress_jv got=%0d exp=0", judge_valid); end
        keys = 4'b0011;
        step();
        checks++; if (judge !== 2'b01) begin failures++; $display("FAIL repress_judge got=%0d exp=1", judge); end
        checks++; if (combo !== 10'd4) begin failures++; $display("FAIL repress_combo got=%0d exp=4", combo); end
        checks++; if (score !== 16'd8) begin failures++; $display("FAIL repress_score got=%0d exp=8", score); end
        keys = 4'd0;
        step();
    endtask

    // Back-to-back windows: each strobe's cycle also completes the previous window.
    task automatic test_back_to_back_saturation();
        logic [3:0] prev;
        logic [3:0] cur;
        apply_reset();
        prev = 4'd0;
        arrow_valid = 1'b1;
        for (int i = 0; i < 21844; i++) begin
            cur = (i % 2 == 1) ? 4'b0010 : 4'b0001;
            arrows = cur;
            keys = prev;
            step();
            prev = cur;
        end
        arrow_valid = 1'b0;
        arrows = 4'd0;
        keys = prev;
        step();
        keys = 4'd0;
        step();
        checks++; if (score !== 16'd65532) begin failures++; $display("FAIL b2b_score got=%0d exp=65532", score); end
        checks++; if (combo !== 10'd1023) begin failures++; $display("FAIL b2b_combo got=%0d exp=1023", combo); end
        checks++; if (max_combo !== 10'd1023) begin failures++; $display("FAIL b2b_max got=%0d exp=1023", max_combo); end

        play_good(4'b0001);
        play_good(4'b0010);
        checks++; if (score !== 16'd65534) begin failures++; $display("FAIL preload_score got=%0d exp=65534", score); end
        play_perfect(4'b0100);
        checks++; if (score !== 16'd65535) begin failures++; $display("FAIL sat_score got=%0d exp=65535", score); end
        checks++; if (judge !== 2'b01) begin failures++; $display("FAIL sat_judge got=%0d exp=1", judge); end
        checks++; if (combo !== 10'd1023) begin failures++; $display("FAIL sat_combo got=%0d exp=1023", combo); end
        play_perfect(4'b1000);
        checks++; if (score !== 16'd65535) begin failures++; $display("FAIL sat_hold got=%0d exp=65535", score); end
    endtask

    initial begin
        test_reset();
        test_perfect();
        test_good_rest();
        test_miss_paths();
        test_edge_cases();
        test_back_to_back_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
